// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word fetches to instruction
// memory, buffers in-order responses and hands {inst, PC, NPC} to decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_take_branch_in,
    input  logic [31:0] ex_target_PC_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    input  logic        id_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        fetch_pc_r;
    logic [CNT_W-1:0]   outstanding_r;
    logic [CNT_W-1:0]   drop_cnt_r;

    logic [31:0]        tag_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   tag_wr_ptr_r;
    logic [PTR_W-1:0]   tag_rd_ptr_r;

    logic [31:0]        inst_mem_r [FIFO_DEPTH];
    logic [31:0]        pc_mem_r   [FIFO_DEPTH];
    logic [31:0]        npc_mem_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]   fifo_wr_ptr_r;
    logic [PTR_W-1:0]   fifo_rd_ptr_r;
    logic [CNT_W-1:0]   fifo_count_r;

    logic               credit_ok_s;
    logic               req_valid_s;
    logic               req_fire_s;
    logic               rsp_accept_s;
    logic               rsp_drop_s;
    logic               rsp_push_s;
    logic               pop_s;
    logic [CNT_W-1:0]   outstanding_nxt_s;
    logic [CNT_W-1:0]   drop_cnt_nxt_s;
    logic [CNT_W:0]     credit_sum_s;

    // Handshake qualification and credit arithmetic
    always_comb begin
        credit_sum_s      = {1'b0, outstanding_r} + {1'b0, fifo_count_r};
        credit_ok_s       = (credit_sum_s < (CNT_W+1)'(FIFO_DEPTH));
        req_fire_s        = req_valid_s && mem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_accept_s      = mem_rsp_valid && (outstanding_r != {CNT_W{1'b0}});
        rsp_drop_s        = rsp_accept_s && ((drop_cnt_r != {CNT_W{1'b0}}) || ex_take_branch_in);
        rsp_push_s        = rsp_accept_s && !rsp_drop_s;
        pop_s             = (fifo_count_r != {CNT_W{1'b0}}) && id_ready && !ex_take_branch_in;
        outstanding_nxt_s = outstanding_r + CNT_W'(req_fire_s) - CNT_W'(rsp_accept_s);
        if (ex_take_branch_in) begin
            // The response accepted in the redirect cycle is already discarded.
            drop_cnt_nxt_s = outstanding_nxt_s;
        end else if ((drop_cnt_r != {CNT_W{1'b0}}) && rsp_accept_s) begin
            drop_cnt_nxt_s = drop_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // FSM next state and request-valid generation
    always_comb begin
        req_valid_s = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: req_valid_s = credit_ok_s && !ex_take_branch_in && !rst;
            ST_FLUSH: req_valid_s = 1'b0;
            default:  req_valid_s = 1'b0;
        endcase
        if (ex_take_branch_in) begin
            state_nxt_s = (drop_cnt_nxt_s != {CNT_W{1'b0}}) ? ST_FLUSH : ST_FETCH;
        end else if ((state_r == ST_FLUSH) && (drop_cnt_nxt_s == {CNT_W{1'b0}})) begin
            state_nxt_s = ST_FETCH;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, fetch PC and in-flight bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
            if (ex_take_branch_in) begin
                fetch_pc_r <= ex_target_PC_in & 32'hFFFF_FFFC;
            end else if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
        end
    end

    // PC tag queue: survives redirects so dropped responses still retire their tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_ptr_r <= {PTR_W{1'b0}};
            tag_rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (req_fire_s) begin
                tag_mem_r[tag_wr_ptr_r] <= fetch_pc_r;
                tag_wr_ptr_r            <= tag_wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (rsp_accept_s) begin
                tag_rd_ptr_r <= tag_rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Instruction buffer toward decode; emptied on redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_ptr_r <= {PTR_W{1'b0}};
            fifo_rd_ptr_r <= {PTR_W{1'b0}};
            fifo_count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
                npc_mem_r[i]  <= 32'h0000_0000;
            end
        end else if (ex_take_branch_in) begin
            fifo_wr_ptr_r <= {PTR_W{1'b0}};
            fifo_rd_ptr_r <= {PTR_W{1'b0}};
            fifo_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (rsp_push_s) begin
                inst_mem_r[fifo_wr_ptr_r] <= mem_rsp_data;
                pc_mem_r[fifo_wr_ptr_r]   <= tag_mem_r[tag_rd_ptr_r];
                npc_mem_r[fifo_wr_ptr_r]  <= tag_mem_r[tag_rd_ptr_r] + 32'd4;
                fifo_wr_ptr_r             <= fifo_wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            fifo_count_r <= fifo_count_r + CNT_W'(rsp_push_s) - CNT_W'(pop_s);
        end
    end

    assign mem_req_valid = req_valid_s;
    assign mem_req_addr  = fetch_pc_r;
    assign if_id_valid   = (fifo_count_r != {CNT_W{1'b0}});
    assign if_id_inst    = inst_mem_r[fifo_rd_ptr_r];
    assign if_id_PC      = pc_mem_r[fifo_rd_ptr_r];
    assign if_id_NPC     = npc_mem_r[fifo_rd_ptr_r];

endmodule
